sector_read_ctrl: RTL and testbench
===================================

SECTOR_READ_CTRL -- requirements
Module: sector_read_ctrl

Interface
REQ-001 SHALL have parameter MAX_REVS, default 2: index pulses tolerated before a search fails.
REQ-002 SHALL have parameter DAM_WINDOW, default 43: valid bytes after header CRC within which the data sync must appear.
REQ-003 SHALL use a single clock domain; reset SHALL be synchronous and active-high.
REQ-004 SHALL have port i_Clk, input, 1: system clock.
REQ-005 SHALL have port i_Reset, input, 1: synchronous active-high reset.
REQ-006 SHALL have port i_Start, input, 1: one-cycle request pulse, sampled only in IDLE.
REQ-007 SHALL have ports i_Track, i_Side, i_Sector, each input, 8: target address, latched on an accepted i_Start.
REQ-008 SHALL have port i_Index, input, 1: one-cycle index pulse, one per revolution.
REQ-009 SHALL have ports i_HdrValid, input, 1, and i_HdrCRCError, input, 1: pulses from the sector header decoder.
REQ-010 SHALL have ports i_HdrTrack, i_HdrSide, i_HdrSector, i_HdrSize, each input, 8: decoded header fields, valid with i_HdrValid.
REQ-011 SHALL have ports i_Sync, input, 1; i_Data, input, 8; i_Valid, input, 1: sync-mark pulse and byte stream from the bit FIFO.
REQ-012 SHALL have port o_Busy, output, 1: high in any state except IDLE.
REQ-013 SHALL have port o_Done, output, 1: one-cycle completion pulse.
REQ-014 SHALL have port o_Status, output, 2: 00 OK, 01 NOT_FOUND, 10 DATA_CRC; held until the next accepted i_Start.
REQ-015 SHALL have ports o_Byte, output, 8; o_ByteValid, output, 1; o_ByteIndex, output, 10: sector payload stream.

Function
REQ-016 SHALL implement states IDLE, SEEK_HDR, WAIT_DAM, CHK_DAM, READ_DATA, READ_CRC, FINISH.
REQ-017 In IDLE, i_Start SHALL latch the target, clear the revolution counter and enter SEEK_HDR on the next cycle; i_Start outside IDLE SHALL be ignored.
REQ-018 In SEEK_HDR, i_HdrValid with track/side/sector equal to the target and i_HdrSize<=3 SHALL latch the size, clear the byte-window counter and enter WAIT_DAM.
REQ-019 A header arriving with i_HdrCRCError high, or with i_HdrSize>3, SHALL be ignored.
REQ-020 In SEEK_HDR and WAIT_DAM, each i_Index SHALL increment the revolution counter; on reaching MAX_REVS the block SHALL enter FINISH with NOT_FOUND.
REQ-021 If a matching i_HdrValid and the limit-reaching i_Index occur in the same cycle, the header SHALL win and the index SHALL not be counted.
REQ-022 In WAIT_DAM, each i_Valid SHALL increment the window counter; reaching DAM_WINDOW without i_Sync SHALL return to SEEK_HDR.
REQ-023 In WAIT_DAM, i_Sync SHALL enter CHK_DAM.
REQ-024 CHK_DAM SHALL preset the CRC to 0xCDB4 (CRC-CCITT 0x1021 over A1 A1 A1 from 0xFFFF).
REQ-025 In CHK_DAM, the first valid byte equal to 0xFB SHALL be fed to the CRC and enter READ_DATA with the byte counter at 0.
REQ-026 In CHK_DAM, any other first valid byte SHALL return to SEEK_HDR.
REQ-027 In READ_DATA, each i_Valid SHALL drive o_Byte=i_Data, o_ByteValid=1 and o_ByteIndex=counter in the following cycle (1-cycle latency), and SHALL feed the CRC.
REQ-028 READ_DATA SHALL transfer 128<<size bytes, then enter READ_CRC.
REQ-029 READ_CRC SHALL feed 2 bytes to the CRC and SHALL not drive o_ByteValid; a residue of 0x0000 SHALL give OK, any other residue DATA_CRC.
REQ-030 i_Sync during READ_DATA or READ_CRC SHALL be ignored; the byte count alone ends the transfer.
REQ-031 i_Index during READ_DATA or READ_CRC SHALL be ignored.
REQ-032 FINISH SHALL pulse o_Done for one cycle with o_Status valid, then return to IDLE.
REQ-033 o_ByteIndex SHALL be 10 bits wide, wrapping never occurs (maximum 1023).

Reset
REQ-034 i_Reset SHALL force IDLE and set o_Busy=0, o_Done=0, o_Status=00, o_Byte=0, o_ByteValid=0, o_ByteIndex=0, and clear all counters and the CRC register.
REQ-035 i_Reset mid-operation SHALL abort without an o_Done pulse.

Structure
REQ-036 State encoding, status codes, the 0xFB mark constant and the 0xCDB4 preset SHALL live in a shared package mfm_pkg.
REQ-037 CRC update SHALL be a sub-module crc16_ccitt with byte-wide update, preset and enable inputs.

Verification
REQ-038 Target 5/0/3 and header 5/0/3 size 2, then sync, FB, 512 bytes and correct CRC -> 512 o_ByteValid with indices 0..511, o_Done with status 00.
REQ-039 Same stimulus with one payload byte flipped -> 512 bytes streamed, then o_Done with status 10.
REQ-040 Only non-matching headers and 2 index pulses -> o_Done with status 01 one cycle-path after the 2nd index.
REQ-041 Matching header, then 43 valid bytes with no sync, then a later good header/data -> first attempt dropped, second completes with status 00.
REQ-042 Matching header and limit index in the same cycle -> search proceeds and no NOT_FOUND is reported.
REQ-043 i_Reset asserted at byte 100 of READ_DATA -> outputs at reset values next cycle, no o_Done; a new i_Start is accepted.

Source files
------------

// File: rtl/mfm_pkg.sv
// Shared definitions for the MFM sector read path: FSM states, status codes,
// address-mark constants and the bytewise CRC-CCITT step.
package mfm_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEEK_HDR  = 3'd1,
    WAIT_DAM  = 3'd2,
    CHK_DAM   = 3'd3,
    READ_DATA = 3'd4,
    READ_CRC  = 3'd5,
    FINISH    = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    STATUS_OK        = 2'b00,
    STATUS_NOT_FOUND = 2'b01,
    STATUS_DATA_CRC  = 2'b10
  } status_t;

  localparam logic [7:0]  DATA_MARK  = 8'hFB;
  // CRC state after the three A1 sync bytes, starting from 0xFFFF
  localparam logic [15:0] CRC_PRESET = 16'hCDB4;
  localparam logic [15:0] CRC_POLY   = 16'h1021;

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ data[i]) begin
        c = {c[14:0], 1'b0} ^ CRC_POLY;
      end else begin
        c = {c[14:0], 1'b0};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/crc16_ccitt.sv
// Byte-wide CRC-CCITT register with preset; o_CrcNext is the value the
// register would take if i_Enable were asserted this cycle.
module crc16_ccitt
  import mfm_pkg::*;
(
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_Preset,
  input  logic        i_Enable,
  input  logic [7:0]  i_Data,
  output logic [15:0] o_CrcNext
);

  logic [15:0] crc_r;
  logic [15:0] base_s;

  // Preset and enable together fold the byte into the preset value
  always_comb begin
    base_s    = i_Preset ? CRC_PRESET : crc_r;
    o_CrcNext = crc16_byte(base_s, i_Data);
  end

  // CRC state register
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      crc_r <= 16'h0000;
    end else if (i_Enable) begin
      crc_r <= o_CrcNext;
    end else if (i_Preset) begin
      crc_r <= CRC_PRESET;
    end else begin
      crc_r <= crc_r;
    end
  end

endmodule

// File: rtl/sector_read_ctrl.sv
// Sector read controller: searches for a matching header, validates the data
// address mark, streams the payload and checks its CRC.
module sector_read_ctrl
  import mfm_pkg::*;
#(
  parameter int MAX_REVS   = 2,
  parameter int DAM_WINDOW = 43
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Start,
  input  logic [7:0] i_Track,
  input  logic [7:0] i_Side,
  input  logic [7:0] i_Sector,
  input  logic       i_Index,
  input  logic       i_HdrValid,
  input  logic       i_HdrCRCError,
  input  logic [7:0] i_HdrTrack,
  input  logic [7:0] i_HdrSide,
  input  logic [7:0] i_HdrSector,
  input  logic [7:0] i_HdrSize,
  input  logic       i_Sync,
  input  logic [7:0] i_Data,
  input  logic       i_Valid,
  output logic       o_Busy,
  output logic       o_Done,
  output logic [1:0] o_Status,
  output logic [7:0] o_Byte,
  output logic       o_ByteValid,
  output logic [9:0] o_ByteIndex
);

  localparam logic [7:0] MAX_REVS_C = 8'(MAX_REVS);
  localparam logic [7:0] DAM_WIN_C  = 8'(DAM_WINDOW);

  state_t      state_r, state_s;
  status_t     status_r, status_s;
  logic [7:0]  tgt_track_r, tgt_track_s;
  logic [7:0]  tgt_side_r, tgt_side_s;
  logic [7:0]  tgt_sector_r, tgt_sector_s;
  logic [1:0]  size_r, size_s;
  logic [7:0]  rev_cnt_r, rev_cnt_s;
  logic [7:0]  win_cnt_r, win_cnt_s;
  logic [9:0]  byte_cnt_r, byte_cnt_s;
  logic        crc_cnt_r, crc_cnt_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic [7:0]  byte_r, byte_s;
  logic        byte_valid_r, byte_valid_s;
  logic [9:0]  byte_index_r, byte_index_s;
  logic        crc_preset_s, crc_en_s;
  logic [15:0] crc_next_s;
  logic        hdr_match_s, rev_limit_s;
  logic [10:0] total_s;
  logic [9:0]  last_idx_s;

  crc16_ccitt u_crc (
    .i_Clk     (i_Clk),
    .i_Reset   (i_Reset),
    .i_Preset  (crc_preset_s),
    .i_Enable  (crc_en_s),
    .i_Data    (i_Data),
    .o_CrcNext (crc_next_s)
  );

  // Next-state and datapath decisions
  always_comb begin
    state_s      = state_r;
    status_s     = status_r;
    tgt_track_s  = tgt_track_r;
    tgt_side_s   = tgt_side_r;
    tgt_sector_s = tgt_sector_r;
    size_s       = size_r;
    rev_cnt_s    = rev_cnt_r;
    win_cnt_s    = win_cnt_r;
    byte_cnt_s   = byte_cnt_r;
    crc_cnt_s    = crc_cnt_r;
    done_s       = 1'b0;
    byte_s       = byte_r;
    byte_valid_s = 1'b0;
    byte_index_s = byte_index_r;
    crc_preset_s = 1'b0;
    crc_en_s     = 1'b0;

    hdr_match_s = i_HdrValid && !i_HdrCRCError && (i_HdrSize <= 8'd3) &&
                  (i_HdrTrack == tgt_track_r) && (i_HdrSide == tgt_side_r) &&
                  (i_HdrSector == tgt_sector_r);
    rev_limit_s = i_Index && ((rev_cnt_r + 8'd1) >= MAX_REVS_C);
    total_s     = 11'd128 << size_r;
    last_idx_s  = 10'(total_s - 11'd1);

    case (state_r)
      IDLE: begin
        if (i_Start) begin
          tgt_track_s  = i_Track;
          tgt_side_s   = i_Side;
          tgt_sector_s = i_Sector;
          rev_cnt_s    = 8'd0;
          status_s     = STATUS_OK;
          state_s      = SEEK_HDR;
        end else begin
          state_s = IDLE;
        end
      end
      SEEK_HDR: begin
        if (hdr_match_s) begin
          size_s    = i_HdrSize[1:0];
          win_cnt_s = 8'd0;
          state_s   = WAIT_DAM;
        end else if (rev_limit_s) begin
          status_s = STATUS_NOT_FOUND;
          done_s   = 1'b1;
          state_s  = FINISH;
        end else if (i_Index) begin
          rev_cnt_s = rev_cnt_r + 8'd1;
        end else begin
          state_s = SEEK_HDR;
        end
      end
      WAIT_DAM: begin
        if (i_Sync) begin
          state_s = CHK_DAM;
        end else if (rev_limit_s) begin
          status_s = STATUS_NOT_FOUND;
          done_s   = 1'b1;
          state_s  = FINISH;
        end else begin
          if (i_Index) begin
            rev_cnt_s = rev_cnt_r + 8'd1;
          end else begin
            rev_cnt_s = rev_cnt_r;
          end
          if (i_Valid) begin
            if ((win_cnt_r + 8'd1) >= DAM_WIN_C) begin
              state_s = SEEK_HDR;
            end else begin
              win_cnt_s = win_cnt_r + 8'd1;
            end
          end else begin
            win_cnt_s = win_cnt_r;
          end
        end
      end
      CHK_DAM: begin
        crc_preset_s = 1'b1;
        if (i_Valid) begin
          if (i_Data == DATA_MARK) begin
            crc_en_s   = 1'b1;
            byte_cnt_s = 10'd0;
            state_s    = READ_DATA;
          end else begin
            state_s = SEEK_HDR;
          end
        end else begin
          state_s = CHK_DAM;
        end
      end
      READ_DATA: begin
        if (i_Valid) begin
          crc_en_s     = 1'b1;
          byte_s       = i_Data;
          byte_valid_s = 1'b1;
          byte_index_s = byte_cnt_r;
          if (byte_cnt_r == last_idx_s) begin
            crc_cnt_s = 1'b0;
            state_s   = READ_CRC;
          end else begin
            byte_cnt_s = byte_cnt_r + 10'd1;
          end
        end else begin
          state_s = READ_DATA;
        end
      end
      READ_CRC: begin
        if (i_Valid) begin
          crc_en_s = 1'b1;
          if (crc_cnt_r) begin
            status_s = (crc_next_s == 16'h0000) ? STATUS_OK : STATUS_DATA_CRC;
            done_s   = 1'b1;
            state_s  = FINISH;
          end else begin
            crc_cnt_s = 1'b1;
          end
        end else begin
          state_s = READ_CRC;
        end
      end
      FINISH: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    busy_s = (state_s != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_r      <= IDLE;
      status_r     <= STATUS_OK;
      tgt_track_r  <= 8'd0;
      tgt_side_r   <= 8'd0;
      tgt_sector_r <= 8'd0;
      size_r       <= 2'd0;
      rev_cnt_r    <= 8'd0;
      win_cnt_r    <= 8'd0;
      byte_cnt_r   <= 10'd0;
      crc_cnt_r    <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      byte_r       <= 8'd0;
      byte_valid_r <= 1'b0;
      byte_index_r <= 10'd0;
    end else begin
      state_r      <= state_s;
      status_r     <= status_s;
      tgt_track_r  <= tgt_track_s;
      tgt_side_r   <= tgt_side_s;
      tgt_sector_r <= tgt_sector_s;
      size_r       <= size_s;
      rev_cnt_r    <= rev_cnt_s;
      win_cnt_r    <= win_cnt_s;
      byte_cnt_r   <= byte_cnt_s;
      crc_cnt_r    <= crc_cnt_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      byte_r       <= byte_s;
      byte_valid_r <= byte_valid_s;
      byte_index_r <= byte_index_s;
    end
  end

  assign o_Busy      = busy_r;
  assign o_Done      = done_r;
  assign o_Status    = status_r;
  assign o_Byte      = byte_r;
  assign o_ByteValid = byte_valid_r;
  assign o_ByteIndex = byte_index_r;

endmodule

// File: tb/tb_sector_read_ctrl.sv
// Directed bench for sector_read_ctrl: a transaction scoreboard of expected
// payload bytes and completion events, checked against the DUT every cycle.
module tb_sector_read_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_Start = 1'b0;
  logic [7:0] i_Track = 8'd0, i_Side = 8'd0, i_Sector = 8'd0;
  logic       i_Index = 1'b0;
  logic       i_HdrValid = 1'b0, i_HdrCRCError = 1'b0;
  logic [7:0] i_HdrTrack = 8'd0, i_HdrSide = 8'd0, i_HdrSector = 8'd0, i_HdrSize = 8'd0;
  logic       i_Sync = 1'b0;
  logic [7:0] i_Data = 8'd0;
  logic       i_Valid = 1'b0;
  logic       o_Busy, o_Done, o_ByteValid;
  logic [1:0] o_Status;
  logic [7:0] o_Byte;
  logic [9:0] o_ByteIndex;

  sector_read_ctrl dut (
    .i_Clk(clk), .i_Reset(rst), .i_Start(i_Start),
    .i_Track(i_Track), .i_Side(i_Side), .i_Sector(i_Sector),
    .i_Index(i_Index), .i_HdrValid(i_HdrValid), .i_HdrCRCError(i_HdrCRCError),
    .i_HdrTrack(i_HdrTrack), .i_HdrSide(i_HdrSide), .i_HdrSector(i_HdrSector),
    .i_HdrSize(i_HdrSize), .i_Sync(i_Sync), .i_Data(i_Data), .i_Valid(i_Valid),
    .o_Busy(o_Busy), .o_Done(o_Done), .o_Status(o_Status), .o_Byte(o_Byte),
    .o_ByteValid(o_ByteValid), .o_ByteIndex(o_ByteIndex)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [7:0] data; logic [9:0] idx; } bexp_t;
  typedef struct { int due; logic [1:0] st; } dexp_t;
  bexp_t exp_b[$];
  dexp_t exp_d[$];
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int bv_count = 0;
  logic [7:0] pay [1024];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Generator CRC: whole byte xored into the high half, then 8 shifts
  function automatic logic [15:0] crc_gen(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  // Per-cycle comparison against the scoreboard
  always @(negedge clk) begin
    while (exp_b.size() > 0 && exp_b[0].due < cyc) begin
      chk("byte_missing", 32'd0, 32'd1);
      void'(exp_b.pop_front());
    end
    if (exp_b.size() > 0 && exp_b[0].due == cyc) begin
      chk("byte_valid", 32'(o_ByteValid), 32'd1);
      chk("byte_data", 32'(o_Byte), 32'(exp_b[0].data));
      chk("byte_index", 32'(o_ByteIndex), 32'(exp_b[0].idx));
      void'(exp_b.pop_front());
    end else begin
      chk("byte_valid_quiet", 32'(o_ByteValid), 32'd0);
    end
    if (o_ByteValid === 1'b1) bv_count++;
    while (exp_d.size() > 0 && exp_d[0].due < cyc) begin
      chk("done_missing", 32'd0, 32'd1);
      void'(exp_d.pop_front());
    end
    if (exp_d.size() > 0 && exp_d[0].due == cyc) begin
      chk("done_pulse", 32'(o_Done), 32'd1);
      chk("done_status", 32'(o_Status), 32'(exp_d[0].st));
      void'(exp_d.pop_front());
    end else begin
      chk("done_quiet", 32'(o_Done), 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    i_Start = 1'b0; i_Index = 1'b0; i_HdrValid = 1'b0; i_HdrCRCError = 1'b0;
    i_Sync = 1'b0; i_Valid = 1'b0;
  endtask

  task automatic start(input logic [7:0] t, input logic [7:0] s, input logic [7:0] sec);
    i_Start = 1'b1; i_Track = t; i_Side = s; i_Sector = sec;
    step();
  endtask

  task automatic header(input logic [7:0] t, input logic [7:0] s, input logic [7:0] sec,
                        input logic [7:0] sz, input logic crcerr, input logic idx);
    i_HdrValid = 1'b1; i_HdrCRCError = crcerr; i_Index = idx;
    i_HdrTrack = t; i_HdrSide = s; i_HdrSector = sec; i_HdrSize = sz;
    step();
  endtask

  task automatic index_pulse(input logic expect_nf);
    i_Index = 1'b1;
    if (expect_nf) exp_d.push_back('{cyc + 1, 2'b01});
    step();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Sync, FB, payload, CRC; abort_at >= 0 asserts reset on that payload byte
  task automatic read_sector(input int size, input int flip_at, input int abort_at,
                             input bit gaps, input logic [1:0] exp_st);
    int n;
    logic [15:0] crc;
    n = 128 << size;
    crc = 16'hFFFF;
    for (int k = 0; k < 3; k++) crc = crc_gen(crc, 8'hA1);
    crc = crc_gen(crc, 8'hFB);
    for (int k = 0; k < n; k++) begin
      pay[k] = 8'(k * 37 + size * 11 + 5);
      crc = crc_gen(crc, pay[k]);
    end
    if (flip_at >= 0) pay[flip_at] = pay[flip_at] ^ 8'h10;
    i_Sync = 1'b1; step();
    step();
    i_Valid = 1'b1; i_Data = 8'hFB; step();
    for (int k = 0; k < n; k++) begin
      if (gaps && (k % 7) == 3) step();
      if (k == abort_at) begin
        rst = 1'b1; i_Valid = 1'b1; i_Data = pay[k];
        step();
        rst = 1'b0;
        return;
      end
      i_Valid = 1'b1; i_Data = pay[k];
      if (k == 10) begin i_Sync = 1'b1; i_Index = 1'b1; end
      exp_b.push_back('{cyc + 1, pay[k], 10'(k)});
      step();
    end
    i_Valid = 1'b1; i_Data = crc[15:8]; step();
    i_Valid = 1'b1; i_Data = crc[7:0];
    exp_d.push_back('{cyc + 1, exp_st});
    step();
  endtask

  initial begin
    logic [15:0] c;
    int base;
    logic [7:0] msg [9];

    // Pin the generator against known CRC-CCITT values
    c = 16'hFFFF;
    for (int k = 0; k < 3; k++) c = crc_gen(c, 8'hA1);
    chk("model_crc_a1", 32'(c), 32'h0000CDB4);
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    c = 16'hFFFF;
    for (int k = 0; k < 9; k++) c = crc_gen(c, msg[k]);
    chk("model_crc_check", 32'(c), 32'h000029B1);

    idle(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(o_Busy), 32'd0);
    chk("rst_status", 32'(o_Status), 32'd0);
    chk("rst_byte", 32'(o_Byte), 32'd0);
    chk("rst_index", 32'(o_ByteIndex), 32'd0);

    // Good 512-byte read, with ignored headers and a stray start
    start(8'd5, 8'd0, 8'd3);
    @(negedge clk);
    chk("busy_after_start", 32'(o_Busy), 32'd1);
    start(8'd7, 8'd7, 8'd7);
    header(8'd5, 8'd0, 8'd2, 8'd2, 1'b0, 1'b0);
    header(8'd5, 8'd0, 8'd3, 8'd2, 1'b1, 1'b0);
    header(8'd5, 8'd0, 8'd3, 8'd4, 1'b0, 1'b0);
    header(8'd5, 8'd0, 8'd3, 8'd2, 1'b0, 1'b0);
    base = bv_count;
    read_sector(2, -1, -1, 1'b0, 2'b00);
    step();
    @(negedge clk);
    chk("count_512", 32'(bv_count - base), 32'd512);
    chk("busy_after_done", 32'(o_Busy), 32'd0);

    // Corrupted payload byte
    start(8'd5, 8'd0, 8'd3);
    header(8'd5, 8'd0, 8'd3, 8'd2, 1'b0, 1'b0);
    base = bv_count;
    read_sector(2, 200, -1, 1'b1, 2'b10);
    idle(2);
    chk("count_512_bad", 32'(bv_count - base), 32'd512);

    // Not found after two revolutions
    start(8'd1, 8'd1, 8'd1);
    header(8'd1, 8'd0, 8'd1, 8'd1, 1'b0, 1'b0);
    index_pulse(1'b0);
    header(8'd2, 8'd1, 8'd1, 8'd1, 1'b0, 1'b0);
    index_pulse(1'b1);
    idle(3);
    @(negedge clk);
    chk("nf_status_held", 32'(o_Status), 32'd1);
    chk("nf_busy", 32'(o_Busy), 32'd0);

    // Data mark window expires, late sync ignored, retry succeeds
    start(8'd9, 8'd1, 8'd4);
    header(8'd9, 8'd1, 8'd4, 8'd0, 1'b0, 1'b0);
    for (int k = 0; k < 43; k++) begin
      i_Valid = 1'b1; i_Data = 8'(k * 13); step();
    end
    i_Sync = 1'b1; step();
    i_Valid = 1'b1; i_Data = 8'hFB; step();
    for (int k = 0; k < 4; k++) begin
      i_Valid = 1'b1; i_Data = 8'(k); step();
    end
    @(negedge clk);
    chk("window_still_busy", 32'(o_Busy), 32'd1);
    header(8'd9, 8'd1, 8'd4, 8'd0, 1'b0, 1'b0);
    base = bv_count;
    read_sector(0, -1, -1, 1'b0, 2'b00);
    idle(2);
    chk("count_128", 32'(bv_count - base), 32'd128);

    // Header and limit-reaching index in the same cycle
    start(8'd2, 8'd0, 8'd7);
    index_pulse(1'b0);
    header(8'd2, 8'd0, 8'd7, 8'd1, 1'b0, 1'b1);
    read_sector(1, -1, -1, 1'b1, 2'b00);
    idle(2);

    // Reset at payload byte 100, then a full 1024-byte read
    start(8'd5, 8'd0, 8'd3);
    header(8'd5, 8'd0, 8'd3, 8'd3, 1'b0, 1'b0);
    read_sector(3, -1, 100, 1'b0, 2'b00);
    @(negedge clk);
    chk("abort_busy", 32'(o_Busy), 32'd0);
    chk("abort_byte", 32'(o_Byte), 32'd0);
    chk("abort_index", 32'(o_ByteIndex), 32'd0);
    chk("abort_status", 32'(o_Status), 32'd0);
    start(8'd5, 8'd0, 8'd3);
    @(negedge clk);
    chk("restart_busy", 32'(o_Busy), 32'd1);
    header(8'd5, 8'd0, 8'd3, 8'd3, 1'b0, 1'b0);
    base = bv_count;
    read_sector(3, -1, -1, 1'b0, 2'b00);
    idle(3);
    chk("count_1024", 32'(bv_count - base), 32'd1024);

    chk("bytes_drained", 32'(exp_b.size()), 32'd0);
    chk("dones_drained", 32'(exp_d.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
